// File: rtl/utype_pkg.sv
// Shared U/J-type definitions: request kinds, opcodes and the instruction encoder
// used by the instruction writer and the control_gen decoder.
package utype_pkg;

  typedef enum logic [1:0] {U_NOP, U_LUI, U_AUIPC, U_JAL} u_kind_e;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_FULL} wr_state_e;

  typedef struct packed {
    u_kind_e     kind;
    logic [4:0]  rd;
    logic [31:0] imm;
  } u_req_t;

  localparam logic [6:0]  OP_LUI   = 7'b0110111;
  localparam logic [6:0]  OP_AUIPC = 7'b0010111;
  localparam logic [6:0]  OP_JAL   = 7'b1101111;
  localparam logic [31:0] NOP_WORD = 32'h0000_0013;

  // JAL drops imm[0]: offsets are always even, misalignment is flagged elsewhere.
  function automatic logic [31:0] encode_u(input u_kind_e kind, input logic [4:0] rd,
                                           input logic [31:0] imm);
    logic [31:0] word;
    unique case (kind)
      U_LUI:   word = {imm[31:12], rd, OP_LUI};
      U_AUIPC: word = {imm[31:12], rd, OP_AUIPC};
      U_JAL:   word = {imm[20], imm[10:1], imm[11], imm[19:12], rd, OP_JAL};
      default: word = NOP_WORD;
    endcase
    return word;
  endfunction

endpackage

// File: rtl/utype_instr_writer_if.sv
// Request handshake bundle carrying U/J-type instruction requests to the writer.
interface utype_instr_writer_if;
  import utype_pkg::*;

  logic        req_valid;
  logic        req_ready;
  u_kind_e     req_kind;
  logic [4:0]  req_rd;
  logic [31:0] req_imm;

  modport master (output req_valid, req_kind, req_rd, req_imm, input req_ready);
  modport slave  (input req_valid, req_kind, req_rd, req_imm, output req_ready);

endinterface

// File: rtl/utype_req_fifo.sv
// Synchronous request FIFO; pointers carry an extra wrap bit to tell full from empty.
module utype_req_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 39
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = (AW + 1)'(1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty    = (wr_ptr == rd_ptr);
  assign full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign do_pop   = pop && !empty;
  // A pop frees the slot in the same cycle, so a full FIFO may still accept.
  assign do_push  = push && (!full || do_pop);
  assign pop_data = mem[rd_ptr[AW-1:0]];

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_ONE;
      if (do_pop)  rd_ptr <= rd_ptr + PTR_ONE;
    end
  end

  // NOTE: storage is not reset; the pointers alone define which entries are valid.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= push_data;
  end

endmodule

// File: rtl/utype_instr_writer.sv
// Buffers U/J-type requests, encodes them to RV32I words and writes them to
// consecutive instruction-memory addresses, one word per cycle.
module utype_instr_writer
  import utype_pkg::*;
#(
  parameter int          FIFO_DEPTH = 4,
  parameter int          MAX_WORDS  = 256,
  parameter logic [31:0] BASE_ADDR  = 32'h0000_0000,
  localparam int         CW         = $clog2(MAX_WORDS) + 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  flush,
  utype_instr_writer_if.slave   req,
  output logic                  imem_we,
  output logic [31:0]           imem_addr,
  output logic [31:0]           imem_wdata,
  output logic                  busy,
  output logic [CW-1:0]         words_done,
  output logic                  align_err,
  output logic                  drop_err
);

  localparam logic [CW-1:0] LAST_WORD = CW'(MAX_WORDS - 1);
  localparam logic [CW-1:0] CNT_ONE   = CW'(1);

  wr_state_e                 state;
  wr_state_e                 state_nxt;
  logic                      fifo_full;
  logic                      fifo_empty;
  logic                      push;
  logic                      pop;
  logic                      reload;
  u_req_t                    push_req;
  u_req_t                    head;
  logic [$bits(u_req_t)-1:0] head_bits;
  logic [31:0]               next_addr;

  assign req.req_ready = (state == S_RUN) && !fifo_full;
  assign push          = req.req_valid && req.req_ready;
  assign push_req      = '{kind: req.req_kind, rd: req.req_rd, imm: req.req_imm};
  assign head          = u_req_t'(head_bits);
  assign busy          = (state != S_IDLE);

  utype_req_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH ($bits(u_req_t))
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .clear     (flush),
    .push      (push),
    .push_data (push_req),
    .pop       (pop),
    .pop_data  (head_bits),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    state_nxt = state;
    pop       = 1'b0;
    reload    = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (start) begin
          state_nxt = S_RUN;
          reload    = 1'b1;
        end
      end
      S_RUN: begin
        pop = !fifo_empty;
        if (start)                               state_nxt = S_DRAIN;
        else if (pop && words_done == LAST_WORD) state_nxt = S_FULL;
      end
      S_DRAIN: begin
        // Finish the old session's words, then restart at the base address.
        if (fifo_empty) begin
          state_nxt = S_RUN;
          reload    = 1'b1;
        end else begin
          pop = 1'b1;
        end
      end
      S_FULL: begin
        if (start) begin
          state_nxt = S_RUN;
          reload    = 1'b1;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
    // Flush outranks everything, including a write that would issue this cycle.
    if (flush) begin
      state_nxt = S_IDLE;
      pop       = 1'b0;
      reload    = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      imem_we    <= 1'b0;
      imem_addr  <= '0;
      imem_wdata <= '0;
      words_done <= '0;
      next_addr  <= BASE_ADDR;
      align_err  <= 1'b0;
      drop_err   <= 1'b0;
    end else begin
      imem_we <= pop;
      if (pop) begin
        imem_addr  <= next_addr;
        imem_wdata <= encode_u(head.kind, head.rd, head.imm);
      end
      if (reload) begin
        next_addr  <= BASE_ADDR;
        words_done <= '0;
      end else if (pop) begin
        next_addr  <= next_addr + 32'd4;
        words_done <= words_done + CNT_ONE;
      end
      if (push && req.req_kind == U_JAL && req.req_imm[0]) align_err <= 1'b1;
      if (state == S_FULL && req.req_valid)                drop_err  <= 1'b1;
    end
  end

endmodule

// File: tb/tb_utype_instr_writer.sv
// Self-checking bench: scoreboard of expected (addr, word) pairs per DUT instance,
// compared whenever the writer strobes imem_we.
module tb_utype_instr_writer;
  import utype_pkg::*;

  localparam logic [31:0] BASE1 = 32'hFFFF_FFF8;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start0 = 1'b0, start1 = 1'b0, flush0 = 1'b0, flush1 = 1'b0;
  logic        we0, we1, busy0, busy1, al0, al1, dr0, dr1;
  logic [31:0] addr0, addr1, data0, data1;
  logic [8:0]  wd0;
  logic [2:0]  wd1;

  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  exp_t        sb0[$], sb1[$];
  int          wc0[$], wc1[$];
  exp_t        e0, e1;
  logic [31:0] ea0 = 32'h0, ea1 = BASE1;
  bit          ok;
  int          acc;
  u_kind_e     rk;
  logic [4:0]  rrd;
  logic [31:0] rimm;
  logic [31:0] held;

  utype_instr_writer_if ri0 ();
  utype_instr_writer_if ri1 ();

  utype_instr_writer dut0 (
    .clk(clk), .rst(rst), .start(start0), .flush(flush0), .req(ri0),
    .imem_we(we0), .imem_addr(addr0), .imem_wdata(data0), .busy(busy0),
    .words_done(wd0), .align_err(al0), .drop_err(dr0)
  );

  utype_instr_writer #(.MAX_WORDS(4), .BASE_ADDR(BASE1)) dut1 (
    .clk(clk), .rst(rst), .start(start1), .flush(flush1), .req(ri1),
    .imem_we(we1), .imem_addr(addr1), .imem_wdata(data1), .busy(busy1),
    .words_done(wd1), .align_err(al1), .drop_err(dr1)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (we0) begin
      wc0.push_back(cyc);
      if (sb0.size() == 0) check("dut0_unexpected_we", 1, 0);
      else begin
        e0 = sb0.pop_front();
        check("dut0_addr", addr0, e0.addr);
        check("dut0_data", data0, e0.data);
      end
    end
    if (we1) begin
      wc1.push_back(cyc);
      if (sb1.size() == 0) check("dut1_unexpected_we", 1, 0);
      else begin
        e1 = sb1.pop_front();
        check("dut1_addr", addr1, e1.addr);
        check("dut1_data", data1, e1.data);
      end
    end
  end

  function automatic logic [31:0] enc(input u_kind_e k, input logic [4:0] rd, input logic [31:0] imm);
    logic [31:0] w;
    case (k)
      U_LUI:   w = (imm & 32'hFFFF_F000) | (32'(rd) << 7) | 32'h37;
      U_AUIPC: w = (imm & 32'hFFFF_F000) | (32'(rd) << 7) | 32'h17;
      U_JAL: begin
        w        = (32'(rd) << 7) | 32'h6F;
        w[31]    = imm[20];
        w[30:21] = imm[10:1];
        w[20]    = imm[11];
        w[19:12] = imm[19:12];
      end
      default: w = 32'h0000_0013;
    endcase
    return w;
  endfunction

  task automatic pulse_start(input bit s);
    if (s) start1 = 1'b1; else start0 = 1'b1;
    @(posedge clk); #1;
    start0 = 1'b0;
    start1 = 1'b0;
    if (s) ea1 = BASE1; else ea0 = 32'h0;
  endtask

  task automatic expect_word(input bit s, input logic [31:0] w);
    exp_t e;
    if (s) begin
      e.addr = ea1; e.data = w; sb1.push_back(e); ea1 = ea1 + 32'd4;
    end else begin
      e.addr = ea0; e.data = w; sb0.push_back(e); ea0 = ea0 + 32'd4;
    end
  endtask

  // Holds valid until ready is seen (accepted on the following edge) or the budget expires.
  task automatic send(input bit s, input u_kind_e k, input logic [4:0] rd, input logic [31:0] imm,
                      input int budget, output bit accepted, output int acc_cyc);
    int n = 0;
    if (s) begin
      ri1.req_valid = 1'b1; ri1.req_kind = k; ri1.req_rd = rd; ri1.req_imm = imm;
    end else begin
      ri0.req_valid = 1'b1; ri0.req_kind = k; ri0.req_rd = rd; ri0.req_imm = imm;
    end
    while (!(s ? ri1.req_ready : ri0.req_ready) && n < budget) begin
      @(posedge clk); #1;
      n++;
    end
    accepted = s ? ri1.req_ready : ri0.req_ready;
    acc_cyc  = cyc;
    if (accepted) begin
      @(posedge clk); #1;
    end
    ri0.req_valid = 1'b0;
    ri1.req_valid = 1'b0;
  endtask

  task automatic send_exp(input bit s, input u_kind_e k, input logic [4:0] rd, input logic [31:0] imm,
                          input logic [31:0] w);
    bit a;
    int c;
    send(s, k, rd, imm, 20, a, c);
    check("accept", 32'(a), 1);
    if (a) expect_word(s, w);
  endtask

  initial begin
    ri0.req_valid = 1'b0; ri0.req_kind = U_NOP; ri0.req_rd = '0; ri0.req_imm = '0;
    ri1.req_valid = 1'b0; ri1.req_kind = U_NOP; ri1.req_rd = '0; ri1.req_imm = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_we", 32'(we0), 0);
    check("rst_addr", addr0, 0);
    check("rst_wdata", data0, 0);
    check("rst_busy", 32'(busy0), 0);
    check("rst_words_done", 32'(wd0), 0);
    check("rst_flags", 32'({al0, dr0}), 0);
    check("rst_ready", 32'(ri0.req_ready), 0);
    rst = 1'b0;
    @(posedge clk); #1;

    // Single LUI: latency and one-cycle strobe
    pulse_start(0);
    check("start_busy", 32'(busy0), 1);
    check("start_ready", 32'(ri0.req_ready), 1);
    wc0.delete();
    send(0, U_LUI, 5'd5, 32'h1234_5000, 20, ok, acc);
    check("lui_accept", 32'(ok), 1);
    expect_word(0, 32'h1234_52B7);
    repeat (4) @(posedge clk);
    #1;
    check("lui_we_cycles", wc0.size(), 1);
    if (wc0.size() > 0) check("lui_latency", wc0[0], acc + 2);
    check("lui_words_done", 32'(wd0), 1);

    // Re-start while running: drain, then new session at address 0
    pulse_start(0);
    repeat (2) @(posedge clk);
    #1;
    check("restart_words_done", 32'(wd0), 0);
    check("restart_busy", 32'(busy0), 1);
    wc0.delete();
    send_exp(0, U_AUIPC, 5'd1, 32'h0000_1000, 32'h0000_1097);
    send_exp(0, U_JAL,   5'd1, 32'h0000_0008, 32'h0080_00EF);
    send_exp(0, U_JAL,   5'd0, 32'hFFFF_FFFC, 32'hFFDF_F06F);
    repeat (4) @(posedge clk);
    #1;
    check("b2b_count", wc0.size(), 3);
    if (wc0.size() == 3) begin
      check("b2b_gap1", wc0[1] - wc0[0], 1);
      check("b2b_gap2", wc0[2] - wc0[1], 1);
    end
    check("b2b_words_done", 32'(wd0), 3);
    check("even_jal_no_align", 32'(al0), 0);

    // Random stream: same-cycle accept/pop, order preserved
    for (int i = 0; i < 16; i++) begin
      rk   = u_kind_e'(2'($urandom_range(0, 3)));
      rrd  = 5'($urandom);
      rimm = $urandom;
      if (rk == U_JAL) rimm[0] = 1'b0;
      send_exp(0, rk, rrd, rimm, enc(rk, rrd, rimm));
    end
    send_exp(0, U_NOP, 5'd7, 32'hDEAD_BEEF, 32'h0000_0013);
    check("pre_odd_align", 32'(al0), 0);
    send_exp(0, U_JAL, 5'd0, 32'h0000_0005, 32'h0040_006F);
    check("odd_jal_align", 32'(al0), 1);
    repeat (4) @(posedge clk);
    #1;
    check("stream_words_done", 32'(wd0), 21);
    check("stream_sb_empty", sb0.size(), 0);

    // Flush with a write pending: it must never appear
    send_exp(0, U_LUI, 5'd2, 32'hAAAA_A000, enc(U_LUI, 5'd2, 32'hAAAA_A000));
    send_exp(0, U_LUI, 5'd3, 32'hBBBB_B000, enc(U_LUI, 5'd3, 32'hBBBB_B000));
    send_exp(0, U_LUI, 5'd4, 32'hCCCC_C000, enc(U_LUI, 5'd4, 32'hCCCC_C000));
    flush0 = 1'b1;
    @(posedge clk); #1;
    flush0 = 1'b0;
    check("flush_dropped", sb0.size(), 1);
    sb0.delete();
    check("flush_we", 32'(we0), 0);
    check("flush_busy", 32'(busy0), 0);
    check("flush_ready", 32'(ri0.req_ready), 0);
    check("flush_keeps_align", 32'(al0), 1);
    wc0.delete();
    repeat (3) @(posedge clk);
    #1;
    pulse_start(0);
    repeat (5) @(posedge clk);
    #1;
    check("flush_fifo_empty", wc0.size(), 0);
    check("flush_restart_ready", 32'(ri0.req_ready), 1);

    // MAX_WORDS=4 instance with wrapping base address
    pulse_start(1);
    for (int i = 0; i < 4; i++)
      send_exp(1, U_LUI, 5'(i + 1), 32'(i) << 12, enc(U_LUI, 5'(i + 1), 32'(i) << 12));
    send(1, U_AUIPC, 5'd9, 32'h0009_9000, 20, ok, acc);
    check("held_accept", 32'(ok), 1);
    held = enc(U_AUIPC, 5'd9, 32'h0009_9000);
    send(1, U_LUI, 5'd10, 32'h0000_A000, 4, ok, acc);
    check("full_rejects", 32'(ok), 0);
    repeat (2) @(posedge clk);
    #1;
    check("full_words_done", 32'(wd1), 4);
    check("full_ready", 32'(ri1.req_ready), 0);
    check("full_busy", 32'(busy1), 1);
    check("full_drop_err", 32'(dr1), 1);
    check("full_sb_empty", sb1.size(), 0);
    pulse_start(1);
    expect_word(1, held);
    repeat (3) @(posedge clk);
    #1;
    check("restart_full_words", 32'(wd1), 1);
    send_exp(1, U_LUI, 5'd11, 32'h0001_1000, enc(U_LUI, 5'd11, 32'h0001_1000));
    send_exp(1, U_LUI, 5'd12, 32'h0001_2000, enc(U_LUI, 5'd12, 32'h0001_2000));
    repeat (4) @(posedge clk);
    #1;
    check("wrap_words_done", 32'(wd1), 3);
    check("wrap_sb_empty", sb1.size(), 0);

    // Reset mid-stream: no partial write, all outputs cleared
    send_exp(0, U_LUI, 5'd6, 32'h6666_6000, enc(U_LUI, 5'd6, 32'h6666_6000));
    send_exp(0, U_LUI, 5'd7, 32'h7777_7000, enc(U_LUI, 5'd7, 32'h7777_7000));
    rst = 1'b1;
    @(posedge clk); #1;
    sb0.delete();
    sb1.delete();
    check("midrst_we", 32'(we0), 0);
    check("midrst_addr", addr0, 0);
    check("midrst_wdata", data0, 0);
    check("midrst_busy", 32'(busy0), 0);
    check("midrst_words_done", 32'(wd0), 0);
    check("midrst_flags", 32'({al0, dr0, dr1}), 0);
    rst = 1'b0;
    wc0.delete();
    repeat (3) @(posedge clk);
    #1;
    check("midrst_no_write", wc0.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
